// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
//   Receive end of the serial shift path. Bits arrive LSB first, one per
//   cycle with Bit_En high, and are assembled into a WIDTH-bit word that is
//   handed to the consumer through a one-entry valid/ready output buffer.
//   The bit order matches a right-shifting transmit register whose serial
//   output is its bit [0], so a word shifted out of that register is
//   rebuilt here unchanged.
//
// Ports
//   Clk         clock; all state changes on the rising edge
//   Reset       synchronous, active-high; overrides every other input
//   Bit_In      serial data bit
//   Bit_En      Bit_In is valid this cycle
//   Clear       abort the partial word and clear Overrun
//   Data_Ready  consumer accepts Data_Out this cycle
//   Data_Out    assembled word (output buffer)
//   Data_Valid  Data_Out holds a word the consumer has not taken yet
//   Busy        a partial word is in progress
//   Bit_Count   bits collected so far in the current word, 0..WIDTH-1
//   Overrun     sticky; a completed word was dropped because the buffer was full
module serial_word_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Bit_In,
    input  logic                       Bit_En,
    input  logic                       Clear,
    input  logic                       Data_Ready,
    output logic [WIDTH-1:0]           Data_Out,
    output logic                       Data_Valid,
    output logic                       Busy,
    output logic [$clog2(WIDTH)-1:0]   Bit_Count,
    output logic                       Overrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   sr_q, sr_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0]   dout_q, dout_n;
    logic               dvalid_q, dvalid_n;
    logic               ovr_q, ovr_n;

    // Word as it would stand after shifting in this cycle's bit.
    logic [WIDTH-1:0]   shifted;
    assign shifted = {Bit_In, sr_q[WIDTH-1:1]};

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            sr_q     <= sr_n;
            cnt_q    <= cnt_n;
            dout_q   <= dout_n;
            dvalid_q <= dvalid_n;
            ovr_q    <= ovr_n;
        end
    end

    // Next-state, shift, count and output-buffer logic.
    always_comb begin
        state_n  = state_q;
        sr_n     = sr_q;
        cnt_n    = cnt_q;
        dout_n   = dout_q;
        dvalid_n = dvalid_q;
        ovr_n    = ovr_q;

        // Consumer takes the buffered word; a completion below may refill it.
        if (dvalid_q && Data_Ready) begin
            dvalid_n = 1'b0;
        end

        // Clear wins over Bit_En: the bit on this edge is dropped and no
        // word can complete. The output buffer is left alone.
        if (Clear) begin
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
            ovr_n   = 1'b0;
        end else if (Bit_En) begin
            sr_n = shifted;
            unique case (state_q)
                IDLE: begin
                    state_n = COLLECT;
                    cnt_n   = CNT_W'(1);
                end
                COLLECT: begin
                    if (cnt_q == LAST_BIT) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        // Buffer can accept if empty or draining this edge.
                        if (!dvalid_q || Data_Ready) begin
                            dout_n   = shifted;
                            dvalid_n = 1'b1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign Data_Out   = dout_q;
    assign Data_Valid = dvalid_q;
    assign Busy       = (state_q == COLLECT);
    assign Bit_Count  = cnt_q;
    assign Overrun    = ovr_q;

endmodule
